// File: rtl/wave_density_streamer_if.sv
// wave_density_streamer_if: site-memory read port plus 8-bit pixel stream
interface wave_density_streamer_if #(parameter int ADDR_W = 10);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_pixel;
  logic              m_sof;
  logic              m_eol;
  modport master (output mem_rd_en, mem_rd_addr, m_valid, m_pixel, m_sof, m_eol,
                  input mem_rd_data, m_ready);
  modport slave  (input mem_rd_en, mem_rd_addr, m_valid, m_pixel, m_sof, m_eol,
                  output mem_rd_data, m_ready);
endinterface

// File: rtl/wave_density_streamer.sv
// wave_density_streamer: raster-scans the wavefunction memory, streams |psi|^2 pixels, totals frame norm
module wave_density_streamer #(
  parameter int MESH_X     = 32,
  parameter int MESH_Y     = 32,
  parameter int ADDR_W     = 10,
  parameter int PIX_SHIFT  = 8,
  parameter int ACC_W      = 48,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  wave_density_streamer_if.master   io,
  output logic [ACC_W-1:0]          norm_sum,
  output logic                      norm_valid
);
  localparam int N  = MESH_X * MESH_Y;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int XW = $clog2(MESH_X);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x;
  logic              v0, v1;
  logic [2:0]        t0, t1;
  logic [31:0]       re2, im2, sum, shifted;
  logic signed [31:0] re, im;
  logic [7:0]        pix;
  logic [PW:0]       count;
  logic [PW-1:0]     wp, rp;
  logic [10:0]       fifo [FIFO_DEPTH];
  logic [10:0]       head;
  logic [ACC_W-1:0]  acc, norm_q;
  logic [ACC_W:0]    acc_add;
  logic              issue, push, pop;
  // credit: buffered pixels plus reads still in the two-stage pipe must leave room
  always_comb begin
    issue   = state == SCAN &&
              ({1'b0, count} + (PW+2)'(v0) + (PW+2)'(v1)) < (PW+2)'(FIFO_DEPTH);
    re      = {{16{io.mem_rd_data[31]}}, io.mem_rd_data[31:16]};
    im      = {{16{io.mem_rd_data[15]}}, io.mem_rd_data[15:0]};
    sum     = re2 + im2;
    shifted = sum >> PIX_SHIFT;
    pix     = |shifted[31:8] ? 8'hFF : shifted[7:0];
    acc_add = {1'b0, acc} + {{(ACC_W+1-32){1'b0}}, sum};
    push    = v1;
    head    = fifo[rp];
    io.m_valid     = count != '0;
    io.m_pixel     = head[7:0];
    io.m_sof       = head[8];
    io.m_eol       = head[9];
    io.mem_rd_en   = issue;
    io.mem_rd_addr = addr;
    pop        = io.m_valid & io.m_ready;
    done       = pop & head[10];
    norm_valid = done;
    norm_sum   = done ? acc : norm_q;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      x      <= '0;
      v0     <= 1'b0;
      v1     <= 1'b0;
      t0     <= '0;
      t1     <= '0;
      re2    <= '0;
      im2    <= '0;
      count  <= '0;
      wp     <= '0;
      rp     <= '0;
      acc    <= '0;
      norm_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      v0  <= issue;
      v1  <= v0;
      t0  <= {addr == ADDR_W'(N-1), x == XW'(MESH_X-1), addr == '0};
      t1  <= t0;
      re2 <= re * re;
      im2 <= im * im;
      if (push) begin
        fifo[wp] <= {t1, pix};
        wp       <= wp + 1'b1;
        acc      <= acc_add[ACC_W] ? '1 : acc_add[ACC_W-1:0];
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (state == IDLE && start) begin
        state <= SCAN;
        addr  <= '0;
        x     <= '0;
        acc   <= '0;
      end
      if (issue) begin
        addr <= addr + 1'b1;
        x    <= x == XW'(MESH_X-1) ? '0 : x + 1'b1;
        if (addr == ADDR_W'(N-1)) state <= DRAIN;
      end
      if (done) begin
        state  <= IDLE;
        norm_q <= acc;
      end
    end
endmodule

// File: tb/tb_wave_density_streamer.sv
// tb_wave_density_streamer: table-driven frame vectors plus reset/latency sequences
module tb_wave_density_streamer;
  localparam int N = 1024;
  typedef struct {
    logic [15:0] re, im;
    int          hot;
    logic [7:0]  pix_bg, pix_hot;
    longint      norm;
    bit          rnd_ready, rnd_field, mid_start;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, busy, done, norm_valid;
  logic [47:0] norm_sum;
  logic [31:0] mem [N];
  logic [7:0]  exp_pix [N];
  logic [7:0]  got [N];
  int cyc = 0, checks = 0, errors = 0;
  int issued, xfers, first_rd, first_valid, first_x, last_x, done_cnt, done_idx;
  int credit_err, addr_err, stall_err, tag_err, busy_err, nv_err;
  longint got_norm;
  bit stalled, busy_chk;
  logic [9:0] held;
  vec_t vec [6];
  wave_density_streamer_if #(.ADDR_W(10)) io();
  wave_density_streamer dut (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
                             .io(io), .norm_sum(norm_sum), .norm_valid(norm_valid));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) io.mem_rd_data <= mem[io.mem_rd_addr];
  always @(negedge clk) if (rst_n) begin
    if (io.mem_rd_en) begin
      if (issued - xfers >= 4) credit_err++;
      if (issued >= N || io.mem_rd_addr != issued[9:0]) addr_err++;
      if (first_rd < 0) first_rd = cyc;
      issued++;
    end
    if (io.m_valid && first_valid < 0) first_valid = cyc;
    if (stalled && (!io.m_valid || {io.m_pixel, io.m_sof, io.m_eol} != held)) stall_err++;
    stalled = io.m_valid && !io.m_ready;
    held = {io.m_pixel, io.m_sof, io.m_eol};
    if (busy_chk && busy) busy_err++;
    busy_chk = done;
    if (io.m_valid && io.m_ready) begin
      if (xfers < N) begin
        got[xfers] = io.m_pixel;
        if (io.m_sof != (xfers == 0) || io.m_eol != (xfers % 32 == 31)) tag_err++;
      end
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      xfers++;
    end
    if (done) begin
      done_cnt++;
      done_idx = xfers;
      got_norm = longint'(norm_sum);
      if (!norm_valid) nv_err++;
    end else if (norm_valid) nv_err++;
  end
  function automatic longint site_sum(input logic [31:0] d);
    longint r = longint'($signed(d[31:16]));
    longint i = longint'($signed(d[15:0]));
    return r * r + i * i;
  endfunction
  function automatic logic [7:0] ref_pix(input logic [31:0] d);
    longint s = site_sum(d) >> 8;
    return s > 255 ? 8'd255 : 8'(s);
  endfunction
  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask
  task automatic clear_mon();
    issued = 0; xfers = 0; first_rd = -1; first_valid = -1; first_x = -1; last_x = -1;
    done_cnt = 0; done_idx = -1; credit_err = 0; addr_err = 0; stall_err = 0; tag_err = 0;
    busy_err = 0; nv_err = 0; got_norm = -1; stalled = 0; busy_chk = 0;
  endtask
  task automatic run_frame(input bit rnd_ready, input bit mid_start, input longint prev_norm,
                           output int cyc_s);
    clear_mon();
    @(posedge clk); #1 start = 1; m_ready_drive(rnd_ready);
    @(posedge clk); #1 cyc_s = cyc; start = 0;
    for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
      @(posedge clk); #1 m_ready_drive(rnd_ready);
      start = mid_start && k == 50;
      if (k == 20) check("norm_hold", longint'(norm_sum), prev_norm);
    end
    start = 0;
    repeat (4) @(posedge clk);
    #1 io.m_ready = 1;
    check("busy_after", longint'(busy), 0);
  endtask
  task automatic m_ready_drive(input bit rnd);
    io.m_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
  endtask
  task automatic check_reset_outputs(input string name);
    check(name, longint'({busy, done, io.mem_rd_en, io.mem_rd_addr, io.m_valid, io.m_pixel,
                          io.m_sof, io.m_eol, norm_valid}), 0);
    check({name, "_norm"}, longint'(norm_sum), 0);
  endtask
  initial begin
    int cyc_s, bad, first_bad;
    longint en, prev;
    vec[0] = '{16'h00B5, 16'h0000, -1, 8'd127, 8'd0, 64'd33547264,   1'b0, 1'b0, 1'b0};
    vec[1] = '{16'h8000, 16'h8000, -1, 8'd255, 8'd0, 64'd2199023255552, 1'b1, 1'b0, 1'b0};
    vec[2] = '{16'h0080, 16'h0080, 33, 8'd0,   8'd128, 64'd32768,    1'b0, 1'b0, 1'b0};
    vec[3] = '{16'h0010, 16'hFFF0, -1, 8'd2,   8'd0, 64'd524288,     1'b0, 1'b0, 1'b1};
    vec[4] = '{16'h0100, 16'h0100, -1, 8'd255, 8'd0, 64'd134217728,  1'b1, 1'b0, 1'b0};
    vec[5] = '{16'h0000, 16'h0000, -1, 8'd0,   8'd0, 64'd0,          1'b1, 1'b1, 1'b0};
    io.m_ready = 1;
    for (int i = 0; i < N; i++) mem[i] = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    rst_n = 1;
    @(posedge clk); #1 check_reset_outputs("idle_after_reset");
    for (int r = 0; r < 6; r++) begin
      en = vec[r].norm;
      if (vec[r].rnd_field) en = 0;
      for (int i = 0; i < N; i++) begin
        if (vec[r].rnd_field) begin
          mem[i] = $urandom;
          exp_pix[i] = ref_pix(mem[i]);
          en += site_sum(mem[i]);
        end else begin
          mem[i] = (vec[r].hot < 0 || vec[r].hot == i) ? {vec[r].re, vec[r].im} : 32'h0;
          exp_pix[i] = (vec[r].hot == i) ? vec[r].pix_hot : vec[r].pix_bg;
        end
      end
      prev = longint'(norm_sum);
      run_frame(vec[r].rnd_ready, vec[r].mid_start, prev, cyc_s);
      bad = 0; first_bad = -1;
      for (int i = 0; i < N; i++) if (got[i] !== exp_pix[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (bad != 0) $display("row %0d first bad pixel %0d got %0d want %0d", r, first_bad,
                             got[first_bad], exp_pix[first_bad]);
      check($sformatf("row%0d_pixels_bad", r), bad, 0);
      check($sformatf("row%0d_xfers", r), xfers, N);
      check($sformatf("row%0d_reads", r), issued, N);
      check($sformatf("row%0d_tags", r), tag_err, 0);
      check($sformatf("row%0d_done_cnt", r), done_cnt, 1);
      check($sformatf("row%0d_done_idx", r), done_idx, N);
      check($sformatf("row%0d_norm", r), got_norm, en);
      check($sformatf("row%0d_norm_held", r), longint'(norm_sum), en);
      check($sformatf("row%0d_credit", r), credit_err, 0);
      check($sformatf("row%0d_addr", r), addr_err, 0);
      check($sformatf("row%0d_stall", r), stall_err, 0);
      check($sformatf("row%0d_busy_drop", r), busy_err, 0);
      check($sformatf("row%0d_norm_valid", r), nv_err, 0);
      if (!vec[r].rnd_ready) begin
        check($sformatf("row%0d_first_rd", r), first_rd - cyc_s, 0);
        check($sformatf("row%0d_first_valid", r), first_valid - cyc_s, 3);
        check($sformatf("row%0d_burst", r), last_x - first_x, N - 1);
      end
    end
    for (int i = 0; i < N; i++) mem[i] = {16'h00B5, 16'h0000};
    clear_mon();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int k = 0; k < 3000 && xfers < 500; k++) @(negedge clk);
    check("reached_pixel_500", longint'(xfers >= 500), 1);
    #2 rst_n = 0;
    #1 check_reset_outputs("reset_mid_frame");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 check_reset_outputs("after_mid_reset");
    run_frame(1'b0, 1'b0, 0, cyc_s);
    check("rescan_xfers", xfers, N);
    check("rescan_done_cnt", done_cnt, 1);
    check("rescan_norm", got_norm, 33547264);
    check("rescan_tags", tag_err, 0);
    check("rescan_addr", addr_err, 0);
    check("rescan_first_valid", first_valid - cyc_s, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_density_streamer.md
Name: wave_density_streamer

Overview:
- Downstream readout stage of the ARA-WAVE field engine.
- Scans the wavefunction memory (one complex_t per site, Q8.8 re/im from wave_pkg) in raster order.
- Computes |Ψ|² per site and streams 8-bit intensity pixels over a valid/ready interface to the visualisation/framebuffer path.
- Accumulates total frame norm Σ|Ψ|² for host-side conservation monitoring.

Parameters:
MESH_X, 32, grid width in sites (wave_pkg WAVE_MESH_X)
MESH_Y, 32, grid height in sites (wave_pkg WAVE_MESH_Y)
ADDR_W, 10, memory address width, equals log2(MESH_X*MESH_Y)
PIX_SHIFT, 8, right shift applied to the 32-bit Q16.16 |Ψ|² before 8-bit saturation
ACC_W, 48, norm accumulator width
FIFO_DEPTH, 4, output buffer depth, power of two, ≥4

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one frame scan; sampled only in IDLE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse: last pixel handshaked
mem_rd_en  out  1  site read strobe
mem_rd_addr  out  ADDR_W  site address = y*MESH_X + x
mem_rd_data  in  32  complex_t, re [31:16], im [15:0]; valid exactly 1 cycle after mem_rd_en
m_valid  out  1  pixel valid
m_ready  in  1  sink ready
m_pixel  out  8  intensity
m_sof  out  1  pixel is site 0
m_eol  out  1  pixel has x == MESH_X-1
norm_sum  out  ACC_W  frame Σ|Ψ|² (raw Q16.16 units), held until next start
norm_valid  out  1  one-cycle pulse, coincident with done

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; FSM IDLE; FIFO empty; address counter 0; accumulator 0.
  - Reset mid-frame discards everything; no partial done.
- FSM:
  - IDLE --start--> SCAN: accumulator cleared, address 0.
  - SCAN: issues reads; after address MESH_X*MESH_Y-1 is issued --> DRAIN.
  - DRAIN: no reads; waits for FIFO empty and in-flight 0 --> IDLE.
  - done and norm_valid pulse in the cycle the last pixel handshakes; busy drops the next cycle.
  - start outside IDLE is ignored.
  - start in the same cycle as done is ignored.
- Read issue:
  - mem_rd_en=1 in SCAN only when (fifo_count + in_flight) < FIFO_DEPTH, using registered counts.
  - Address increments by 1 per issued read; no wrap within a frame.
- Pipeline:
  - P1 (cycle after read): register re², im² as signed 16×16 products.
  - P2: sum = re² + im², 32-bit unsigned, cannot overflow (max 0x8000_0000).
  - P2: pixel = min(sum >> PIX_SHIFT, 255); push to FIFO with sof/eol tags.
  - P2: accumulator += sum, saturating at 2^ACC_W-1.
- Latency:
  - First mem_rd_en occurs the cycle after start is sampled.
  - FIFO push occurs 2 cycles after the read issue.
  - m_valid rises the cycle after the first push, i.e. 4 cycles after start.
- Handshake:
  - Transfer when m_valid & m_ready.
  - m_pixel, m_sof, m_eol are stable while m_valid & !m_ready.
  - m_valid never drops without a transfer.
- Throughput: with m_ready held high, one pixel per cycle after the first; a 32×32 frame takes 1024 consecutive transfer cycles.
- FIFO:
  - Simultaneous push and pop when full or empty is handled: count unchanged, no loss.
  - Overflow is impossible by the credit rule; a bench assertion checks this.
- Order: pixels emerge in strict address order; exactly MESH_X*MESH_Y pixels per frame.
- norm_sum updates only at done; it holds its prior value during a scan.

Test Plan:
- Uniform re=0x00B5, im=0 → all 1024 pixels = 127 (32761>>8); norm_sum = 33,547,264; one done pulse.
- Saturation: re=im=0x8000 everywhere → pixels 255; norm_sum = 1024·2^31 = 2^41.
- Single hot site addr 33: re=im=0x0080, rest 0 → pixel 33 = 128, others 0; norm_sum = 32768; m_sof only on pixel 0; m_eol on pixels 31, 63, …, 1023.
- Random m_ready (30% low), random field → output matches reference model in order, no drop/dup, stable data during stalls, FIFO never overflows, read strobe never violates credit.
- m_ready held high → first m_valid 4 cycles after start; 1024 transfers in 1024 consecutive cycles; done on the last; busy low next cycle.
- start pulsed mid-scan → ignored. rst_n asserted at pixel 500 → all outputs 0 immediately. A new start rescans from addr 0 with correct norm.
